// File: rtl/uart_duty_rx.sv
// 8N1 UART receiver that latches each good byte into the held PWM duty register.
// Bad stop bits raise a one-cycle error pulse and park the FSM until the line returns high.
module uart_duty_rx #(
   parameter int          BAUD_DIV   = 1042,
   parameter logic [7:0]  DUTY_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       rst_i,
   input  logic       rx_i,
   input  logic       en_i,
   output logic [7:0] duty_o,
   output logic       duty_valid_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int CW   = $clog2(BAUD_DIV);
   localparam int HALF = BAUD_DIV / 2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_rx_m, r_rx_s;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [2:0]      r_idx, w_idx_nxt;
   logic [7:0]      r_sr, w_sr_nxt;
   logic            w_load, w_err, w_exp, w_half;

   assign w_exp  = (r_cnt == CW'(BAUD_DIV - 1));
   assign w_half = (r_cnt == CW'(HALF - 1));
   assign busy_o = (r_state != S_IDLE);

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_idx_nxt   = r_idx;
      w_sr_nxt    = r_sr;
      w_load      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (!r_rx_s) w_state_nxt = S_START;
         end
         S_START: if (w_half) begin
            // Start bit must still be low at its centre, otherwise it was a glitch
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: if (w_exp) begin
            w_cnt_nxt = '0;
            w_sr_nxt  = {r_rx_s, r_sr[7:1]};
            w_idx_nxt = r_idx + 3'd1;
            if (r_idx == 3'd7) w_state_nxt = S_STOP;
         end
         S_STOP: if (w_exp) begin
            w_cnt_nxt = '0;
            if (r_rx_s) begin
               w_load      = en_i;
               w_state_nxt = S_IDLE;
            end else begin
               w_err       = 1'b1;
               w_state_nxt = S_BREAK;
            end
         end
         S_BREAK: begin
            w_cnt_nxt = '0;
            if (r_rx_s) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_rx_m       <= 1'b1;
         r_rx_s       <= 1'b1;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_sr         <= '0;
         duty_o       <= DUTY_RESET;
         duty_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         r_rx_m       <= rx_i;
         r_rx_s       <= r_rx_m;
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_sr         <= w_sr_nxt;
         if (w_load) duty_o <= r_sr;
         duty_valid_o <= w_load;
         frame_err_o  <= w_err;
      end
   end

endmodule

// File: tb/tb_uart_duty_rx.sv
// Bench for uart_duty_rx: a fast instance (16 clk/bit) and a nominal one (1042 clk/bit).
// Frames are queued as expected events with a decision window; one process scores every cycle.
module tb_uart_duty_rx;

   localparam int B0 = 16;
   localparam int B1 = 1042;

   logic       clk = 1'b0;
   logic       rst [2];
   logic       rx  [2];
   logic       en  [2];
   logic [7:0] duty [2];
   logic       dv [2], fe [2], busy [2];

   always #5 clk = ~clk;

   uart_duty_rx #(.BAUD_DIV(B0), .DUTY_RESET(8'h00)) u0 (
      .clk(clk), .rst_i(rst[0]), .rx_i(rx[0]), .en_i(en[0]),
      .duty_o(duty[0]), .duty_valid_o(dv[0]), .frame_err_o(fe[0]), .busy_o(busy[0]));

   uart_duty_rx #(.BAUD_DIV(B1), .DUTY_RESET(8'h00)) u1 (
      .clk(clk), .rst_i(rst[1]), .rx_i(rx[1]), .en_i(en[1]),
      .duty_o(duty[1]), .duty_valid_o(dv[1]), .frame_err_o(fe[1]), .busy_o(busy[1]));

   typedef struct {
      int         d;
      bit         err;
      logic [7:0] val;
      longint     lo;
      longint     hi;
   } ev_t;

   ev_t        q[$];
   longint     cyc = 0;
   int         vectors = 0, miscompares = 0;
   logic [7:0] model_duty [2];
   int         cnt_dv [2], cnt_fe [2];
   longint     last_dv_cyc [2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int bdiv(input int d);
      return (d == 0) ? B0 : B1;
   endfunction

   // Scoreboard: every pulse must match the head event inside its window
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst[d]) begin
            if (dv[d] || fe[d]) begin
               vectors++;
               if (q.size() == 0 || q[0].d != d) begin
                  miscompares++;
                  $display("FAIL unexpected_pulse dut%0d cyc %0d: dv=%0b fe=%0b, required no pulse", d, cyc, dv[d], fe[d]);
               end else begin
                  if (dv[d] != !q[0].err || fe[d] != q[0].err || cyc < q[0].lo || cyc > q[0].hi) begin
                     miscompares++;
                     $display("FAIL pulse dut%0d cyc %0d: dv=%0b fe=%0b, required dv=%0b fe=%0b in [%0d,%0d]",
                              d, cyc, dv[d], fe[d], !q[0].err, q[0].err, q[0].lo, q[0].hi);
                  end
                  if (!q[0].err) model_duty[d] = q[0].val;
                  void'(q.pop_front());
               end
               if (dv[d]) last_dv_cyc[d] = cyc;
            end
            cnt_dv[d] += int'(dv[d]);
            cnt_fe[d] += int'(fe[d]);
            vectors++;
            if (duty[d] !== model_duty[d]) begin
               miscompares++;
               $display("FAIL duty dut%0d cyc %0d: got %02h, required %02h", d, cyc, duty[d], model_duty[d]);
            end
         end
      end
      if (q.size() > 0 && cyc > q[0].hi) begin
         vectors++;
         miscompares++;
         $display("FAIL missed_pulse dut%0d cyc %0d: no pulse, required err=%0b val=%02h by %0d",
                  q[0].d, cyc, q[0].err, q[0].val, q[0].hi);
         void'(q.pop_front());
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Drive one frame; cut>0 abandons it after that many cycles (no event queued)
   task automatic drive_frame(input int d, input logic [7:0] b, input bit stop, input int per, input int cut);
      logic [9:0] fr;
      longint     n;
      int         bd, h;
      fr = {stop, b, 1'b0};
      n  = cyc;
      bd = bdiv(d);
      h  = bd / 2;
      if (cut == 0 && (!stop || en[d]))
         q.push_back('{d: d, err: !stop, val: b, lo: n + 1 + h + 9 * bd, hi: n + 3 + h + 9 * bd});
      for (int t = 0; t < 10 * per; t++) begin
         if (cut != 0 && t == cut) return;
         rx[d] = fr[t / per];
         tick(1);
      end
   endtask

   task automatic do_reset(input int d);
      rst[d] = 1'b1;
      q.delete();
      model_duty[d] = 8'h00;
      #1;
      chk($sformatf("rst_duty_dut%0d", d), int'(duty[d]), 8'h00);
      chk($sformatf("rst_busy_dut%0d", d), int'(busy[d]), 0);
      chk($sformatf("rst_dv_dut%0d", d), int'(dv[d]), 0);
      chk($sformatf("rst_fe_dut%0d", d), int'(fe[d]), 0);
      rx[d] = 1'b1;
      tick(3);
      rst[d] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, f0;
      longint st;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; rx[d] = 1'b1; en[d] = 1'b1;
         model_duty[d] = 8'h00; cnt_dv[d] = 0; cnt_fe[d] = 0; last_dv_cyc[d] = 0;
      end
      tick(3);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_duty_dut%0d", d), int'(duty[d]), 8'h00);
         chk($sformatf("reset_busy_dut%0d", d), int'(busy[d]), 0);
         chk($sformatf("reset_pulses_dut%0d", d), int'(dv[d]) + int'(fe[d]), 0);
      end
      rst[0] = 1'b0; rst[1] = 1'b0;
      tick(5);

      // First frame: latency and value pinned by hand
      st = cyc;
      drive_frame(0, 8'h80, 1'b1, B0, 0);
      tick(4);
      chk("first_duty", int'(duty[0]), 8'h80);
      chk("first_model", int'(model_duty[0]), 8'h80);
      chk("first_dv_count", cnt_dv[0], 1);
      chk("first_fe_count", cnt_fe[0], 0);
      chk_rng("first_latency", last_dv_cyc[0] - st, 153, 155);

      // Back-to-back, zero idle gap
      n0 = cnt_dv[0];
      drive_frame(0, 8'h00, 1'b1, B0, 0);
      drive_frame(0, 8'hFF, 1'b1, B0, 0);
      drive_frame(0, 8'h5A, 1'b1, B0, 0);
      tick(2);
      chk("b2b_dv_count", cnt_dv[0] - n0, 3);
      chk("b2b_duty", int'(duty[0]), 8'h5A);
      chk("b2b_busy_after", int'(busy[0]), 0);

      // Bad stop bit followed by a 40-bit break
      n0 = cnt_dv[0]; f0 = cnt_fe[0];
      drive_frame(0, 8'h3C, 1'b0, B0, 0);
      tick(40 * B0);
      chk("break_busy", int'(busy[0]), 1);
      rx[0] = 1'b1;
      tick(20);
      chk("break_fe_count", cnt_fe[0] - f0, 1);
      chk("break_dv_count", cnt_dv[0] - n0, 0);
      chk("break_duty_held", int'(duty[0]), 8'h5A);
      drive_frame(0, 8'h42, 1'b1, B0, 0);
      tick(4);
      chk("after_break_duty", int'(duty[0]), 8'h42);

      // Start-bit glitch
      n0 = cnt_dv[0]; f0 = cnt_fe[0];
      rx[0] = 1'b0; tick(3); rx[0] = 1'b1;
      tick(30);
      chk("glitch_pulses", (cnt_dv[0] - n0) + (cnt_fe[0] - f0), 0);
      chk("glitch_duty", int'(duty[0]), 8'h42);
      chk("glitch_busy", int'(busy[0]), 0);

      // Enable gating
      n0 = cnt_dv[0];
      en[0] = 1'b0;
      drive_frame(0, 8'hA5, 1'b1, B0, 0);
      tick(4);
      chk("en0_dv_count", cnt_dv[0] - n0, 0);
      chk("en0_duty", int'(duty[0]), 8'h42);
      en[0] = 1'b1;
      drive_frame(0, 8'h11, 1'b1, B0, 0);
      tick(4);
      chk("en1_dv_count", cnt_dv[0] - n0, 1);
      chk("en1_duty", int'(duty[0]), 8'h11);

      // Reset in the middle of data bit 4
      drive_frame(0, 8'hC3, 1'b1, B0, 5 * B0 + B0 / 2);
      chk("midframe_busy", int'(busy[0]), 1);
      do_reset(0);
      tick(30);
      drive_frame(0, 8'h07, 1'b1, B0, 0);
      tick(4);
      chk("post_reset_duty", int'(duty[0]), 8'h07);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         bit stop;
         b    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         en[0] = ($urandom_range(0, 3) != 0);
         drive_frame(0, b, stop, B0, 0);
         if (!stop) begin
            tick($urandom_range(20, 60));
            rx[0] = 1'b1;
            tick($urandom_range(4, 20));
         end
         tick($urandom_range(0, 30));
      end
      en[0] = 1'b1;
      tick(10);

      // Nominal rate: reset mid-frame, then skewed frames at +2% and -2%
      drive_frame(1, 8'hC3, 1'b1, B1, 5 * B1 + B1 / 2);
      chk("nom_midframe_busy", int'(busy[1]), 1);
      do_reset(1);
      tick(50);
      drive_frame(1, 8'h07, 1'b1, (B1 * 102) / 100, 0);
      tick(4);
      chk("nom_slow_duty", int'(duty[1]), 8'h07);
      drive_frame(1, 8'h5A, 1'b1, (B1 * 98) / 100, 0);
      tick(600);
      chk("nom_fast_duty", int'(duty[1]), 8'h5A);
      chk("nom_dv_count", cnt_dv[1], 2);

      tick(20);
      chk("events_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
